// File: rtl/duck_hunt_pkg.sv
// Shared types for the flash-frame light-gun path: detector state and the
// phase code the pattern generator turns into black/white frames.
package duck_hunt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    BLACK  = 3'd2,
    WHITE  = 3'd3,
    REPORT = 3'd4,
    HELD   = 3'd5
  } zap_state_e;

  localparam logic [1:0] PHASE_NORMAL = 2'b00;
  localparam logic [1:0] PHASE_BLACK  = 2'b01;
  localparam logic [1:0] PHASE_WHITE  = 2'b10;

endpackage

// File: rtl/zapper_hit_detector_if.sv
// Pattern-generator / game-logic side of the zapper hit detector.
// master = detector, slave = pattern generator + game logic.
interface zapper_hit_detector_if;
  logic       frame_start;
  logic       valid;
  logic       flash_req;
  logic [1:0] phase;
  logic       hit;
  logic       miss;
  logic       busy;

  modport master (input frame_start, valid,
                  output flash_req, phase, hit, miss, busy);
  modport slave  (output frame_start, valid,
                  input flash_req, phase, hit, miss, busy);
endinterface

// File: rtl/zapper_hit_detector_sync.sv
// sync_debounce: SYNC_STAGES-deep synchronizer for an asynchronous gun pin,
// optionally followed by a level debouncer (USE_DEBOUNCE).
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit USE_DEBOUNCE    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  generate
    if (USE_DEBOUNCE) begin : g_deb
      localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [DW-1:0] stable_cnt;
      logic          lvl;

      // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stable_cnt <= '0;
          lvl        <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == lvl) begin
          stable_cnt <= '0;
        end else if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_cnt <= '0;
          lvl        <= sync_q[SYNC_STAGES-1];
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end

      assign dout = lvl;
    end else begin : g_nodeb
      assign dout = sync_q[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/zapper_hit_detector.sv
// Light-gun hit detector: trigger -> black frame -> white frame -> hit/miss pulse.
// Optional trigger debouncer enabled by defining ZAPPER_TRIGGER_DEBOUNCE_EN.
module zapper_hit_detector
  import duck_hunt_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 20,
  parameter int LIGHT_MIN       = 1000,
  parameter int DARK_MAX        = 16,
  parameter int FRAME_TIMEOUT   = 1000000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trigger,
  input  logic                         light,
  zapper_hit_detector_if.master        bus
);

`ifdef ZAPPER_TRIGGER_DEBOUNCE_EN
  localparam bit TRG_DEBOUNCE = 1'b1;
`else
  localparam bit TRG_DEBOUNCE = 1'b0;
`endif

  localparam int               TMO_W    = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic trg_lvl, light_sync, trg_q, trg_rise;

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .USE_DEBOUNCE(TRG_DEBOUNCE)
  ) u_trg_sync (
    .clk(clk), .rst_n(rst_n), .din(trigger), .dout(trg_lvl)
  );

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .USE_DEBOUNCE(1'b0)
  ) u_light_sync (
    .clk(clk), .rst_n(rst_n), .din(light), .dout(light_sync)
  );

  assign trg_rise = trg_lvl & ~trg_q;

  zap_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [TMO_W-1:0] tmo, tmo_d;
  logic             dark_ok, dark_ok_d;
  logic             verdict, verdict_d;
  logic             sample, cnt_inc;

  assign sample  = bus.valid & light_sync;
  assign cnt_inc = sample && (cnt != CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tmo     <= '0;
      dark_ok <= 1'b0;
      verdict <= 1'b0;
      trg_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      tmo     <= tmo_d;
      dark_ok <= dark_ok_d;
      verdict <= verdict_d;
      trg_q   <= trg_lvl;
    end
  end

  // The frame_start that ends a phase is never itself counted as a sample.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    tmo_d     = tmo;
    dark_ok_d = dark_ok;
    verdict_d = verdict;
    case (state)
      IDLE: begin
        if (trg_rise) begin
          state_d = ARM;
          tmo_d   = '0;
        end
      end
      ARM: begin
        if (bus.frame_start) begin
          state_d = BLACK;
          cnt_d   = '0;
        end else if (tmo == TMO_LAST) begin
          state_d   = REPORT;
          verdict_d = 1'b0;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      BLACK: begin
        if (bus.frame_start) begin
          dark_ok_d = (32'(cnt) <= 32'(DARK_MAX));
          cnt_d     = '0;
          state_d   = WHITE;
        end else if (cnt_inc) begin
          cnt_d = cnt + 1'b1;
        end
      end
      WHITE: begin
        if (bus.frame_start) begin
          verdict_d = dark_ok && (32'(cnt) >= 32'(LIGHT_MIN));
          state_d   = REPORT;
        end else if (cnt_inc) begin
          cnt_d = cnt + 1'b1;
        end
      end
      REPORT:  state_d = HELD;
      HELD:    if (!trg_lvl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.phase = PHASE_NORMAL;
    case (state)
      BLACK:   bus.phase = PHASE_BLACK;
      WHITE:   bus.phase = PHASE_WHITE;
      default: bus.phase = PHASE_NORMAL;
    endcase
  end

  assign bus.flash_req = (state == ARM) || (state == BLACK) || (state == WHITE);
  assign bus.hit       = (state == REPORT) &&  verdict;
  assign bus.miss      = (state == REPORT) && !verdict;
  assign bus.busy      = (state != IDLE);

endmodule

// File: doc/zapper_hit_detector.md
Name: zapper_hit_detector

Overview:
- Light-gun end of the flash-frame handshake.
- On a trigger pull it requests a black frame followed by a white frame from the pattern generator, and samples the photodiode during each frame.
- It issues a one-cycle hit or miss verdict to game logic.
- It sits between the gun I/O pins and the pattern/game logic, in the pixel-clock domain.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the trigger and light inputs.
- CNT_W, 20: width of the light-sample counter; the counter saturates at all-ones.
- LIGHT_MIN, 1000: minimum bright samples in the white frame for a hit.
- DARK_MAX, 16: maximum bright samples allowed in the black frame.
- FRAME_TIMEOUT, 1000000: cycles allowed in ARM waiting for frame_start before forcing a miss.
- DEBOUNCE_CYCLES, 50000: stable-trigger cycles required; used only with the optional feature.

Ports:
- clk, in, 1: pixel clock.
- rst_n, in, 1: asynchronous active-low reset.
- trigger, in, 1: raw gun trigger; asynchronous, active-high.
- light, in, 1: raw photodiode output; asynchronous, 1 = bright.
- frame_start, in, 1: one-cycle pulse at the start of each frame; synchronous to clk.
- valid, in, 1: pixel is in the active display area.
- flash_req, out, 1: high while a flash sequence is in progress.
- phase, out, 2: 00 = normal, 01 = black frame, 10 = white frame; 11 is never driven.
- hit, out, 1: one-cycle verdict pulse.
- miss, out, 1: one-cycle verdict pulse.
- busy, out, 1: state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, dark_ok 0, synchronizers 0.
- trigger and light each pass through a SYNC_STAGES synchronizer. trg_rise is the synchronized trigger, registered and rising-edge detected.
- State machine, one transition per clock edge:
  - IDLE: on trg_rise, go to ARM. frame_start is ignored in IDLE. If trg_rise and frame_start coincide, that frame_start is not consumed; the black phase begins at the next frame_start.
  - ARM: flash_req=1, phase=00, timeout counter running. On frame_start, go to BLACK and clear the sample counter. If the timeout counter reaches FRAME_TIMEOUT-1, go to REPORT with verdict miss.
  - BLACK: phase=01. Each cycle with valid && light_sync, increment the counter (saturating). On frame_start: dark_ok <= (count <= DARK_MAX), clear the counter, go to WHITE.
  - WHITE: phase=10, counting as in BLACK. On frame_start: verdict = dark_ok && (count >= LIGHT_MIN), go to REPORT.
  - REPORT: exactly one cycle; hit=verdict, miss=!verdict; go to HELD.
  - HELD: stay until the synchronized trigger is 0, then go to IDLE. This blocks auto-fire.
- flash_req=1 in ARM, BLACK and WHITE; 0 elsewhere.
- hit and miss are mutually exclusive and are never both high.
- Latency: the verdict appears one cycle after the frame_start that ends WHITE.
- Counting rules:
  - A sample on the same cycle as the phase-ending frame_start is not counted.
  - The counter is cleared on the phase-entering edge.
  - Saturation at 2^CNT_W-1 must not wrap.
- Releasing the trigger mid-sequence does not abort; the sequence completes and reports.
- rst_n asserted at any point forces IDLE immediately. An in-flight verdict is discarded and no pulse is emitted.

Optional Feature:
- Macro ZAPPER_TRIGGER_DEBOUNCE_EN.
- Defined: the synchronized trigger feeds a debouncer. The debounced level changes only after the input is stable for DEBOUNCE_CYCLES consecutive cycles. trg_rise and HELD use the debounced level. Trigger-to-ARM latency becomes SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Undefined: no debouncer; latency from trigger to ARM is SYNC_STAGES+1 cycles.

Decomposition:
- Shared package (duck_hunt_pkg):
  - hit-detector state enum: IDLE, ARM, BLACK, WHITE, REPORT, HELD.
  - phase encoding constants: PHASE_NORMAL, PHASE_BLACK, PHASE_WHITE, matching the pattern generator's colours.
- One natural sub-module: sync_debounce. It holds the synchronizer plus the optional debouncer and is instantiated for trigger; the light input uses the synchronizer only.

Test Plan (LIGHT_MIN=4, DARK_MAX=1, FRAME_TIMEOUT=100, valid=1):
- Hit:
  - Stimulus: trigger rise; frame_start; 0 light samples in BLACK; frame_start; 10 light samples in WHITE; frame_start.
  - Response: phase 00→01→10; hit=1 for exactly one cycle; miss=0; then HELD until trigger falls; then IDLE with busy=0.
- Lamp-aim cheat:
  - Stimulus: light held at 1 through both frames.
  - Response: BLACK count >1, so dark_ok=0; miss=1 one cycle; hit=0.
- Weak white:
  - Stimulus: 3 light samples in WHITE.
  - Response: miss; with exactly 4 samples, hit.
- Timeout:
  - Stimulus: trigger rise with no frame_start for 100 cycles.
  - Response: miss pulse on cycle 101 after ARM entry; flash_req drops.
- Auto-fire and reset:
  - Stimulus A: trigger held high after a verdict.
  - Response A: no new ARM.
  - Stimulus B: rst_n low during WHITE.
  - Response B: all outputs 0 immediately; no hit or miss pulse; IDLE after release.
- Coincident edge:
  - Stimulus: trg_rise and frame_start on the same cycle.
  - Response: ARM entered; BLACK starts only at the next frame_start.
